taylor_ctrl: RTL and testbench
==============================

Name: taylor_ctrl

Overview:
- Control unit that drives the series-evaluation datapath (comb_part) and consumes its `done` and `gt` status flags.
- Runs one series evaluation per accepted request:
  - loads the operand X;
  - iterates multiply / multiply-by-coefficient / accumulate until the term counter reports `done`;
  - holds the result valid until the consumer acknowledges it.
- Provides the start/ready request handshake and the valid/ack result handshake at the system level.

Parameters:
- MUL_LAT, 1, extra wait cycles after each `load_m` so the multiplier result settles; range 0..7.
- MAX_ITER, 16, watchdog limit on accumulate steps per evaluation; must be ≥ the datapath term count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted when `start && ready`.
- mode_in  in  1  function select, sampled on acceptance.
- ack  in  1  consumer takes the result; effective only while `out_valid`.
- done  in  1  datapath term counter exhausted.
- gt  in  1  datapath comparator: |term| > epsilon.
- counter_en  out  1  advance the datapath term counter / LUT address.
- sel_1  out  1  multiplier operand A: 0 = reg_x, 1 = reg_m.
- sel_2  out  1  multiplier operand B: 0 = reg_x, 1 = LUT coefficient.
- sel_x  out  1  reg_x source: 0 = external X, 1 = hold/feedback.
- sel_t  out  1  reg_t source: 0 = initial constant (1.0 in Q format), 1 = reg_t + reg_m.
- load_x, load_m, load_t  out  1 each  register write enables.
- mode  out  1  latched `mode_in`, stable for the whole evaluation.
- ready  out  1  idle and able to accept a request.
- busy  out  1  evaluation in progress.
- out_valid  out  1  `out` of the datapath holds the final result.
- timeout  out  1  sticky; MAX_ITER was reached without `done`; cleared on the next accept.

Behaviour:
- Reset values:
  - `ready` = 1.
  - All other outputs = 0, including `mode`, `timeout` and the iteration counter.
  - State = IDLE.
  - `rst` overrides any state, including mid-evaluation; no partial result is flagged valid.
- All outputs are Moore outputs decoded from state; the datapath sees stable controls for a full cycle.
- States and transitions:
  - IDLE: `ready` = 1. On `start`: latch `mode`, clear `timeout` and the iteration counter, go to INIT. `start` while not `ready` is ignored; nothing is queued.
  - INIT (1 cycle): `load_x` = 1, `sel_x` = 0, `load_t` = 1, `sel_t` = 0, `load_m` = 1, `sel_1` = 0, `sel_2` = 0 (m ← x·x; `mode` = 1 uses the odd series, in which the datapath treats m as x). Go to MUL_X.
  - MUL_X: `load_m` = 1, `sel_1` = 1, `sel_2` = 0 (m ← m·x). Go to WAIT_X when MUL_LAT > 0, else MUL_C.
  - WAIT_X: hold all enables at 0 for exactly MUL_LAT cycles, then go to MUL_C.
  - MUL_C: `load_m` = 1, `sel_1` = 1, `sel_2` = 1 (m ← m·coef[k]). Go to WAIT_C or ACC by the same MUL_LAT rule.
  - WAIT_C: MUL_LAT cycles, then ACC.
  - ACC (1 cycle): `load_t` = 1, `sel_t` = 1, `counter_en` = 1, increment the iteration counter. Go to CHECK.
  - CHECK (1 cycle, all enables 0):
    - `done` = 1 → FIN;
    - else iteration counter == MAX_ITER → set `timeout`, FIN;
    - else → MUL_X.
  - FIN: `out_valid` = 1, `busy` = 0. On `ack` → IDLE. `ready` rises the cycle after `ack`. `start` asserted together with `ack` is not accepted.
- `busy` = 1 in every state except IDLE and FIN.
- Latency with MUL_LAT = L and N terms: 1 (INIT) + N·(4 + 2L) cycles from the accept edge to `out_valid`.
- `done` and `gt` are sampled only in CHECK and ignored elsewhere.
- The iteration counter is ceil(log2(MAX_ITER+1)) bits and saturates; it never wraps.

Optional Feature:
- Macro: EARLY_TERM_EN.
- Defined: in CHECK, `gt` = 0 (term below epsilon) also exits to FIN, with priority `done` > `gt` = 0 > timeout. Convergence leaves `timeout` = 0.
- Undefined: `gt` is ignored; termination is by `done` or timeout only.

Decomposition:
- Package `taylor_pkg`:
  - state enum `ctrl_state_t` {IDLE, INIT, MUL_X, WAIT_X, MUL_C, WAIT_C, ACC, CHECK, FIN};
  - localparams for the `sel_*` encodings (SEL_X_EXT = 0, SEL_T_INIT = 0, SEL_OPB_LUT = 1, ...);
  - default MUL_LAT.
- Sub-module `wait_counter`:
  - parameterised down-counter with load/enable/zero flag;
  - used for both WAIT states and reused by a future pipelined multiplier.

Test Plan:
- Reset mid-evaluation: assert `rst` while in MUL_C → next cycle state IDLE, `ready` = 1, all enables 0, `out_valid` = 0.
- Nominal run, MUL_LAT = 1, `done` forced high at the 4th CHECK → exactly 4 `counter_en` pulses; `out_valid` at cycle 1 + 4·6 = 25 after accept; `timeout` = 0.
- Handshake: hold `ack` = 0 for 10 cycles in FIN → `out_valid` stays 1 and all enables stay 0; `ack` = 1 → IDLE; `ready` = 1 one cycle later; `start` on the `ack` cycle is ignored.
- Watchdog, MAX_ITER = 16, `done` tied 0 → FIN after 16 ACC pulses, `timeout` = 1; `timeout` stays 1 until the next accept, which clears it.
- Mode latch: `mode_in` = 1 at accept, toggled every cycle afterwards → `mode` stays 1 until FIN.
- EARLY_TERM_EN defined, `gt` = 0 at the 2nd CHECK with `done` = 0 → FIN after 2 iterations, `timeout` = 0. The same stimulus without the macro runs to `done` or timeout.

Source files
------------

// File: rtl/taylor_pkg.sv
// Shared types and encodings for the series-evaluation controller.
package taylor_pkg;

  localparam int unsigned MUL_LAT_DEF  = 1;
  localparam int unsigned MAX_ITER_DEF = 16;

  // Multiplier operand A select
  localparam logic SEL_OPA_X   = 1'b0;
  localparam logic SEL_OPA_M   = 1'b1;
  // Multiplier operand B select
  localparam logic SEL_OPB_X   = 1'b0;
  localparam logic SEL_OPB_LUT = 1'b1;
  // reg_x source (reg_x holds whenever load_x is low)
  localparam logic SEL_X_EXT   = 1'b0;
  // reg_t source
  localparam logic SEL_T_INIT  = 1'b0;
  localparam logic SEL_T_ACC   = 1'b1;

  typedef enum logic [3:0] {
    IDLE, INIT, MUL_X, WAIT_X, MUL_C, WAIT_C, ACC, CHECK, FIN
  } ctrl_state_t;

  // Registered controls handed to the datapath and the request side
  typedef struct packed {
    logic counter_en;
    logic sel_1;
    logic sel_2;
    logic sel_x;
    logic sel_t;
    logic load_x;
    logic load_m;
    logic load_t;
    logic ready;
    logic busy;
    logic out_valid;
  } ctrl_out_t;

  // Bits needed to hold values 0..max_val (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/taylor_ctrl_if.sv
// Request/result handshake between a requester and the series controller.
interface taylor_ctrl_if;

  logic start;
  logic mode_in;
  logic ack;
  logic ready;
  logic busy;
  logic out_valid;
  logic timeout;
  logic mode;

  modport master (
    output start, mode_in, ack,
    input  ready, busy, out_valid, timeout, mode
  );

  modport slave (
    input  start, mode_in, ack,
    output ready, busy, out_valid, timeout, mode
  );

endinterface

// File: rtl/wait_counter.sv
// Loadable down-counter with zero flag; paces multiplier settle cycles.
module wait_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  // Load has priority; decrement stops at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/taylor_ctrl.sv
// Series-evaluation controller: sequences load/multiply/accumulate steps of
// the datapath and handles the start/ready and valid/ack handshakes.
// Optional macro EARLY_TERM_EN: a term below epsilon (gt = 0) in CHECK also ends
// the evaluation, priority done > convergence > watchdog.
module taylor_ctrl
  import taylor_pkg::*;
#(
  parameter int unsigned MUL_LAT  = MUL_LAT_DEF,
  parameter int unsigned MAX_ITER = MAX_ITER_DEF
) (
  input  logic         clk,
  input  logic         rst,
  taylor_ctrl_if.slave sys,
  input  logic         done,
  input  logic         gt,
  output logic         counter_en,
  output logic         sel_1,
  output logic         sel_2,
  output logic         sel_x,
  output logic         sel_t,
  output logic         load_x,
  output logic         load_m,
  output logic         load_t
);

  localparam int unsigned ITER_W = cnt_width(MAX_ITER);
  localparam int unsigned WAIT_W = cnt_width(MUL_LAT);
  localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((MUL_LAT > 0) ? (MUL_LAT - 1) : 0);
  localparam logic              HAS_WAIT  = (MUL_LAT > 0);
  localparam ctrl_out_t         OUTS_RST  = '{ready: 1'b1, default: 1'b0};

  ctrl_state_t       state;
  ctrl_state_t       state_next;
  ctrl_out_t         outs_d;
  ctrl_out_t         outs_q;
  logic [ITER_W-1:0] iter;
  logic              mode_q;
  logic              timeout_q;
  logic              accept_c;
  logic              tmo_hit_c;
  logic              conv_c;
  logic              wait_zero_c;
  logic              wait_load_c;
  logic              wait_en_c;

`ifdef EARLY_TERM_EN
  assign conv_c = ~gt;
`else
  logic unused_gt;
  assign unused_gt = gt;
  assign conv_c    = 1'b0;
`endif

  // Multiplier settle timer shared by both WAIT states
  assign wait_load_c = (state == MUL_X) || (state == MUL_C);
  assign wait_en_c   = (state == WAIT_X) || (state == WAIT_C);

  wait_counter #(
    .W (WAIT_W)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (wait_load_c),
    .en       (wait_en_c),
    .load_val (WAIT_LOAD),
    .zero_c   (wait_zero_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; done/gt only matter in CHECK
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    tmo_hit_c  = 1'b0;
    case (state)
      IDLE: begin
        if (sys.start) begin
          accept_c   = 1'b1;
          state_next = INIT;
        end
      end
      INIT:   state_next = MUL_X;
      MUL_X:  state_next = HAS_WAIT ? WAIT_X : MUL_C;
      WAIT_X: if (wait_zero_c) state_next = MUL_C;
      MUL_C:  state_next = HAS_WAIT ? WAIT_C : ACC;
      WAIT_C: if (wait_zero_c) state_next = ACC;
      ACC:    state_next = CHECK;
      CHECK: begin
        if (done || conv_c) begin
          state_next = FIN;
        end else if (iter == ITER_MAX) begin
          tmo_hit_c  = 1'b1;
          state_next = FIN;
        end else begin
          state_next = MUL_X;
        end
      end
      FIN:     if (sys.ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the upcoming state so registered outputs track state
  always_comb begin
    outs_d       = '0;
    outs_d.sel_1 = SEL_OPA_X;
    outs_d.sel_2 = SEL_OPB_X;
    outs_d.sel_x = SEL_X_EXT;
    outs_d.sel_t = SEL_T_INIT;
    outs_d.busy  = (state_next != IDLE) && (state_next != FIN);
    case (state_next)
      IDLE: outs_d.ready = 1'b1;
      INIT: begin
        outs_d.load_x = 1'b1;
        outs_d.load_t = 1'b1;
        outs_d.load_m = 1'b1;
      end
      MUL_X: begin
        outs_d.load_m = 1'b1;
        outs_d.sel_1  = SEL_OPA_M;
      end
      MUL_C: begin
        outs_d.load_m = 1'b1;
        outs_d.sel_1  = SEL_OPA_M;
        outs_d.sel_2  = SEL_OPB_LUT;
      end
      ACC: begin
        outs_d.load_t     = 1'b1;
        outs_d.sel_t      = SEL_T_ACC;
        outs_d.counter_en = 1'b1;
      end
      FIN:     outs_d.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      outs_q <= OUTS_RST;
    end else begin
      outs_q <= outs_d;
    end
  end

  // Mode latch, sticky watchdog flag and saturating iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= 1'b0;
      timeout_q <= 1'b0;
      iter      <= '0;
    end else if (accept_c) begin
      mode_q    <= sys.mode_in;
      timeout_q <= 1'b0;
      iter      <= '0;
    end else begin
      if ((state == ACC) && (iter != '1)) begin
        iter <= iter + ITER_W'(1);
      end
      if (tmo_hit_c) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign counter_en    = outs_q.counter_en;
  assign sel_1         = outs_q.sel_1;
  assign sel_2         = outs_q.sel_2;
  assign sel_x         = outs_q.sel_x;
  assign sel_t         = outs_q.sel_t;
  assign load_x        = outs_q.load_x;
  assign load_m        = outs_q.load_m;
  assign load_t        = outs_q.load_t;
  assign sys.ready     = outs_q.ready;
  assign sys.busy      = outs_q.busy;
  assign sys.out_valid = outs_q.out_valid;
  assign sys.mode      = mode_q;
  assign sys.timeout   = timeout_q;

endmodule

// File: tb/tb_taylor_ctrl.sv
// Bench for taylor_ctrl: vector table of evaluations with a result scoreboard,
// plus reset and handshake sequences.
module tb_taylor_ctrl;

  localparam int unsigned LAT  = 1;
  localparam int unsigned MAXI = 16;

  logic clk = 1'b0;
  logic rst;
  logic done, gt;
  logic counter_en, sel_1, sel_2, sel_x, sel_t, load_x, load_m, load_t;

  taylor_ctrl_if sys_if ();

  taylor_ctrl #(
    .MUL_LAT  (LAT),
    .MAX_ITER (MAXI)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sys        (sys_if),
    .done       (done),
    .gt         (gt),
    .counter_en (counter_en),
    .sel_1      (sel_1),
    .sel_2      (sel_2),
    .sel_x      (sel_x),
    .sel_t      (sel_t),
    .load_x     (load_x),
    .load_m     (load_m),
    .load_t     (load_t)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Datapath stand-in: done / gt driven from the number of counter_en pulses seen
  int en_cnt      = 0;
  int cur_done_at = 0;
  int cur_gt_at   = 0;
  assign done = (cur_done_at != 0) && (en_cnt >= cur_done_at);
  assign gt   = !((cur_gt_at != 0) && (en_cnt >= cur_gt_at));

  typedef struct {
    int done_at;   // CHECK index where done rises, 0 = never
    int gt_at;     // CHECK index where gt falls, 0 = never
    bit mode;
    int ack_hold;  // cycles in FIN before ack
  } vec_t;

  typedef struct {
    int lat;
    int pulses;
    bit tmo;
    bit mode;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input vec_t v);
    exp_t e;
    int n;
    bit tmo;
    n   = MAXI;
    tmo = 1'b1;
    if (v.done_at != 0 && v.done_at <= MAXI) begin
      n   = v.done_at;
      tmo = 1'b0;
    end
`ifdef EARLY_TERM_EN
    if (v.gt_at != 0 && v.gt_at <= n) begin
      n   = v.gt_at;
      tmo = 1'b0;
    end
`endif
    e.lat    = 1 + n * (4 + 2 * LAT);
    e.pulses = n;
    e.tmo    = tmo;
    e.mode   = v.mode;
    return e;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!sys_if.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!sys_if.ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: ready=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int   lat;
    bit   mode_ok;
    bit   seen;
    wait_ready();
    cur_done_at    = v.done_at;
    cur_gt_at      = v.gt_at;
    en_cnt         = 0;
    sys_if.start   = 1'b1;
    sys_if.mode_in = v.mode;
    sb.push_back(model(v));
    @(posedge clk);
    lat     = 0;
    mode_ok = 1'b1;
    seen    = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c == 0) begin
        sys_if.start = 1'b0;
        check($sformatf("v%0d_tmo_clear_on_accept", idx), 32'(sys_if.timeout), 32'd0);
      end
      sys_if.mode_in = ~sys_if.mode_in;
      if (sys_if.out_valid) begin
        seen = 1'b1;
        break;
      end
      if (counter_en) en_cnt++;
      if (sys_if.mode !== v.mode) mode_ok = 1'b0;
      @(posedge clk);
      lat++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL v%0d_out_valid: not seen within 400 cycles, required by cycle %0d", idx, model(v).lat);
      if (sb.size() > 0) void'(sb.pop_front());
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    e = sb.pop_front();
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(e.lat));
    check($sformatf("v%0d_counter_en_pulses", idx), 32'(en_cnt), 32'(e.pulses));
    check($sformatf("v%0d_timeout", idx), 32'(sys_if.timeout), 32'(e.tmo));
    check($sformatf("v%0d_mode_stable", idx), 32'(mode_ok), 32'd1);
    check($sformatf("v%0d_mode_at_fin", idx), 32'(sys_if.mode), 32'(e.mode));
    for (int h = 0; h < v.ack_hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_fin_hold", idx),
            32'({sys_if.out_valid, sys_if.busy, counter_en, load_x, load_m, load_t}),
            32'b100000);
    end
    // ack with a simultaneous start: start must not be taken
    sys_if.ack   = 1'b1;
    sys_if.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sys_if.ack   = 1'b0;
    sys_if.start = 1'b0;
    check($sformatf("v%0d_ack_to_idle", idx),
          32'({sys_if.ready, sys_if.busy, sys_if.out_valid}), 32'b100);
    check($sformatf("v%0d_tmo_after_ack", idx), 32'(sys_if.timeout), 32'(e.tmo));
  endtask

  task automatic reset_mid_eval();
    wait_ready();
    cur_done_at    = 0;
    cur_gt_at      = 0;
    en_cnt         = 0;
    sys_if.start   = 1'b1;
    sys_if.mode_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sys_if.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_in_mul_c", 32'({load_m, sel_1, sel_2, sys_if.busy}), 32'b1111);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", 32'(sys_if.ready), 32'd1);
    check("mid_rst_outs",
          32'({counter_en, sel_1, sel_2, sel_x, sel_t, load_x, load_m, load_t,
               sys_if.busy, sys_if.out_valid, sys_if.mode, sys_if.timeout}), 32'd0);
  endtask

  initial begin
    vecs[0] = '{done_at: 4,  gt_at: 0, mode: 1'b1, ack_hold: 10};
    vecs[1] = '{done_at: 1,  gt_at: 0, mode: 1'b0, ack_hold: 0};
    vecs[2] = '{done_at: 0,  gt_at: 0, mode: 1'b0, ack_hold: 2};
    vecs[3] = '{done_at: 16, gt_at: 0, mode: 1'b1, ack_hold: 0};
    vecs[4] = '{done_at: 15, gt_at: 0, mode: 1'b0, ack_hold: 1};
    vecs[5] = '{done_at: 0,  gt_at: 2, mode: 1'b1, ack_hold: 0};
    vecs[6] = '{done_at: 2,  gt_at: 2, mode: 1'b0, ack_hold: 0};
    vecs[7] = '{done_at: 3,  gt_at: 1, mode: 1'b1, ack_hold: 0};

    rst            = 1'b1;
    sys_if.start   = 1'b0;
    sys_if.mode_in = 1'b0;
    sys_if.ack     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(sys_if.ready), 32'd1);
    check("rst_outs",
          32'({counter_en, sel_1, sel_2, sel_x, sel_t, load_x, load_m, load_t,
               sys_if.busy, sys_if.out_valid, sys_if.mode, sys_if.timeout}), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i]);
      if (i == 2) reset_mid_eval();
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
